// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, zero-register default and flattened-bus slice helper
package regfile_pkg;
   localparam int ZERO_REG_DEFAULT = 31;
   localparam int ARM_DATA_W = 64;
   localparam int ARM_ADDR_W = 5;
   function automatic int rf_slice(input int idx, input int w);
      return idx * w;
   endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read mux with zero-register, write bypass and busy lookup
module regfile_read_port import regfile_pkg::*; #(
   parameter int DATA_W = ARM_DATA_W,
   parameter int ADDR_W = ARM_ADDR_W,
   parameter int ZERO_REG = ZERO_REG_DEFAULT,
   parameter int BYPASS = 1
) (
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic              i_mem_busy,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_busy
);
   localparam bit HAS_ZERO = ZERO_REG < 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
   logic w_zero, w_byp;
   assign w_zero = HAS_ZERO && i_rd_addr == ZERO_A;
   assign w_byp = BYPASS != 0 && i_wr_en && i_wr_addr == i_rd_addr;
   // Reset masks the bypass too, so a write presented under reset never leaks out.
   assign o_rd_data = (i_rst || w_zero) ? '0 : w_byp ? i_wr_data : i_mem_data;
   assign o_rd_busy = !(i_rst || w_zero || w_byp) && i_mem_busy;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with zero register, write bypass and busy scoreboard
module regfile_scoreboard import regfile_pkg::*; #(
   parameter int DATA_W = ARM_DATA_W,
   parameter int ADDR_W = ARM_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int ZERO_REG = ZERO_REG_DEFAULT,
   parameter int BYPASS = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     claim_en,
   input  logic [ADDR_W-1:0]        claim_addr,
   input  logic                     flush,
   output logic                     busy_any
);
   localparam int DEPTH = 2**ADDR_W;
   localparam bit HAS_ZERO = ZERO_REG < DEPTH;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_busy, w_busy_nxt, w_wr_mask, w_claim_mask;
   logic w_wr_ok, w_claim_ok;
   assign w_wr_ok = wr_en && !(HAS_ZERO && wr_addr == ZERO_A);
   assign w_claim_ok = claim_en && !flush && !(HAS_ZERO && claim_addr == ZERO_A);
   assign w_wr_mask = w_wr_ok ? DEPTH'(1) << wr_addr : '0;
   assign w_claim_mask = w_claim_ok ? DEPTH'(1) << claim_addr : '0;
   // Claim is OR-ed in after the release so a younger producer wins the same edge.
   assign w_busy_nxt = flush ? '0 : (r_busy & ~w_wr_mask) | w_claim_mask;
   assign busy_any = |r_busy;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
         r_busy <= '0;
      end else begin
         if (w_wr_ok) r_mem[wr_addr] <= wr_data;
         r_busy <= w_busy_nxt;
      end
   end
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_read_port #(
         .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
      ) u_port (
         .i_rst     (reset),
         .i_rd_addr (rd_addr[rf_slice(g, ADDR_W) +: ADDR_W]),
         .i_mem_data(r_mem[rd_addr[rf_slice(g, ADDR_W) +: ADDR_W]]),
         .i_mem_busy(r_busy[rd_addr[rf_slice(g, ADDR_W) +: ADDR_W]]),
         .i_wr_en   (wr_en),
         .i_wr_addr (wr_addr),
         .i_wr_data (wr_data),
         .o_rd_data (rd_data[rf_slice(g, DATA_W) +: DATA_W]),
         .o_rd_busy (rd_busy[g])
      );
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors against bypass, no-bypass and three-port instances
module tb_regfile_scoreboard;
   logic clock, reset, wr_en, claim_en, flush;
   logic [4:0] wr_addr, claim_addr;
   logic [63:0] wr_data;
   logic [9:0] ra2;
   logic [14:0] ra3;
   logic [127:0] d_b, d_nb;
   logic [191:0] d_3;
   logic [1:0] b_b, b_nb;
   logic [2:0] b_3;
   logic any_b, any_nb, any_3;
   int errors = 0, checks = 0;

   regfile_scoreboard u_b (.clock(clock), .reset(reset), .rd_addr(ra2), .rd_data(d_b), .rd_busy(b_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr),
      .flush(flush), .busy_any(any_b));
   regfile_scoreboard #(.BYPASS(0)) u_nb (.clock(clock), .reset(reset), .rd_addr(ra2), .rd_data(d_nb),
      .rd_busy(b_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
      .claim_addr(claim_addr), .flush(flush), .busy_any(any_nb));
   regfile_scoreboard #(.NUM_RD(3)) u_3 (.clock(clock), .reset(reset), .rd_addr(ra3), .rd_data(d_3),
      .rd_busy(b_3), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
      .claim_addr(claim_addr), .flush(flush), .busy_any(any_3));

   initial clock = 0;
   always #5 clock = ~clock;

   typedef struct {
      logic we; logic [4:0] wa; logic [63:0] wd;
      logic ce; logic [4:0] ca; logic fl;
      logic [4:0] r0, r1;
      logic [63:0] d0; logic b0; logic [63:0] d1; logic b1; logic any;
   } vec_t;
   vec_t tv[19];

   function automatic vec_t mk(logic we, logic [4:0] wa, logic [63:0] wd, logic ce, logic [4:0] ca,
                               logic fl, logic [4:0] r0, logic [4:0] r1, logic [63:0] d0, logic b0,
                               logic [63:0] d1, logic b1, logic any);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ce = ce; v.ca = ca; v.fl = fl; v.r0 = r0; v.r1 = r1;
      v.d0 = d0; v.b0 = b0; v.d1 = d1; v.b1 = b1; v.any = any;
      return v;
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic idle();
      wr_en = 0; wr_addr = 0; wr_data = 0; claim_en = 0; claim_addr = 0; flush = 0;
   endtask

   localparam logic [63:0] DB = 64'hDEADBEEF_00000001;

   initial begin
      tv[0]  = mk(1, 5, DB,     0, 0, 0,  5, 3,  DB,    0, 0,     0, 0);
      tv[1]  = mk(0, 0, 0,      1, 9, 0,  5, 9,  DB,    0, 0,     0, 0);
      tv[2]  = mk(0, 0, 0,      0, 0, 0,  9, 5,  0,     1, DB,    0, 1);
      tv[3]  = mk(1, 9, 'h42,   0, 0, 0,  9, 9,  'h42,  0, 'h42,  0, 1);
      tv[4]  = mk(0, 0, 0,      0, 0, 0,  9, 31, 'h42,  0, 0,     0, 0);
      tv[5]  = mk(1, 4, 'h11,   1, 4, 0,  4, 31, 'h11,  0, 0,     0, 0);
      tv[6]  = mk(0, 0, 0,      0, 0, 0,  4, 9,  'h11,  1, 'h42,  0, 1);
      tv[7]  = mk(1, 4, 'h22,   1, 4, 1,  4, 4,  'h22,  0, 'h22,  0, 1);
      tv[8]  = mk(0, 0, 0,      0, 0, 0,  4, 5,  'h22,  0, DB,    0, 0);
      tv[9]  = mk(1, 31, 'hFFFF, 1, 31, 0, 31, 31, 0,    0, 0,     0, 0);
      tv[10] = mk(0, 0, 0,      0, 0, 0,  31, 4, 0,     0, 'h22,  0, 0);
      tv[11] = mk(0, 0, 0,      1, 7, 0,  7, 1,  0,     0, 0,     0, 0);
      tv[12] = mk(1, 7, 'h77,   0, 0, 1,  7, 7,  'h77,  0, 'h77,  0, 1);
      tv[13] = mk(0, 0, 0,      0, 0, 0,  7, 3,  'h77,  0, 0,     0, 0);
      tv[14] = mk(0, 0, 0,      1, 3, 0,  3, 3,  0,     0, 0,     0, 0);
      tv[15] = mk(0, 0, 0,      1, 3, 0,  3, 3,  0,     1, 0,     1, 1);
      tv[16] = mk(0, 0, 0,      0, 0, 0,  3, 3,  0,     1, 0,     1, 1);
      tv[17] = mk(1, 3, 'h33,   0, 0, 0,  3, 3,  'h33,  0, 'h33,  0, 1);
      tv[18] = mk(0, 0, 0,      0, 0, 0,  3, 3,  'h33,  0, 'h33,  0, 0);
      idle(); ra2 = 0; ra3 = 0; reset = 1;
      @(negedge clock);
      ra2 = {5'd7, 5'd3};
      #1;
      chk("rst_hold d0", d_b[63:0], 0);
      chk("rst_hold any", 64'(any_b), 0);
      @(negedge clock); reset = 0;
      wr_en = 1; wr_addr = 3; wr_data = 'h3333;
      @(negedge clock); wr_addr = 7; wr_data = 'h7777;
      @(negedge clock); idle(); claim_en = 1; claim_addr = 8;
      @(negedge clock); idle();
      #1;
      chk("preload x3", d_b[63:0], 'h3333);
      chk("preload x7", d_b[127:64], 'h7777);
      chk("preload any", 64'(any_b), 1);
      #2; reset = 1; wr_en = 1; wr_addr = 3; wr_data = 'h99; claim_en = 1; claim_addr = 3;
      #1;
      chk("async rst x3", d_b[63:0], 0);
      chk("async rst x7", d_b[127:64], 0);
      chk("async rst b0", 64'(b_b[0]), 0);
      chk("async rst any", 64'(any_b), 0);
      @(negedge clock); reset = 0; idle();
      #1;
      chk("post rst x3", d_b[63:0], 0);
      chk("post rst b0", 64'(b_b[0]), 0);
      chk("post rst any", 64'(any_b), 0);
      for (int i = 0; i < 19; i++) begin
         @(negedge clock);
         wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
         claim_en = tv[i].ce; claim_addr = tv[i].ca; flush = tv[i].fl;
         ra2 = {tv[i].r1, tv[i].r0};
         #1;
         chk($sformatf("v%0d d0", i), d_b[63:0], tv[i].d0);
         chk($sformatf("v%0d b0", i), 64'(b_b[0]), 64'(tv[i].b0));
         chk($sformatf("v%0d d1", i), d_b[127:64], tv[i].d1);
         chk($sformatf("v%0d b1", i), 64'(b_b[1]), 64'(tv[i].b1));
         chk($sformatf("v%0d any", i), 64'(any_b), 64'(tv[i].any));
      end
      @(negedge clock); idle(); wr_en = 1; wr_addr = 6; wr_data = 'hABCD; ra2 = {5'd6, 5'd6};
      #1;
      chk("byp x6", d_b[63:0], 'hABCD);
      chk("nobyp x6 old", d_nb[63:0], 0);
      @(negedge clock); idle();
      #1;
      chk("nobyp x6 new", d_nb[63:0], 'hABCD);
      @(negedge clock); claim_en = 1; claim_addr = 10; ra2 = {5'd10, 5'd10};
      @(negedge clock); idle(); wr_en = 1; wr_addr = 10; wr_data = 'h10;
      #1;
      chk("nobyp x10 busy", 64'(b_nb[0]), 1);
      chk("nobyp x10 old", d_nb[63:0], 0);
      chk("byp x10 busy", 64'(b_b[0]), 0);
      @(negedge clock); idle();
      #1;
      chk("nobyp x10 rel", 64'(b_nb[0]), 0);
      chk("nobyp x10 data", d_nb[63:0], 'h10);
      chk("nobyp any", 64'(any_nb), 0);
      @(negedge clock); wr_en = 1; wr_addr = 1; wr_data = 'h11112222; ra3 = {5'd31, 5'd1, 5'd1};
      #1;
      chk("p3 port0", d_3[63:0], 'h11112222);
      chk("p3 port1", d_3[127:64], 'h11112222);
      chk("p3 port2", d_3[191:128], 0);
      chk("p3 busy", 64'(b_3), 0);
      @(negedge clock); idle();
      #1;
      chk("p3 x1 stored", d_3[63:0], 'h11112222);
      chk("p3 x31 zero", d_3[191:128], 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised multi-read-port register file for the pipelined ARM datapath, with a hardwired zero register.
- Provides same-cycle write-to-read bypass and a per-register busy scoreboard.
- The decode stage reads operands and claims its destination register; writeback writes data and releases the claim.
- The branch unit flushes all outstanding claims on a mispredict/redirect.

Parameters:
- DATA_W, 64, width of each register.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 31, index that always reads 0 (XZR); any value >= DEPTH disables the feature.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored contents.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  1 = addressed register has an outstanding claim.
- wr_en  in  1  write strobe from writeback.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- claim_en  in  1  decode issues an instruction with a destination.
- claim_addr  in  ADDR_W  destination being claimed.
- flush  in  1  clear every busy bit (pipeline redirect).
- busy_any  out  1  OR of all busy bits (drain indicator).

Behaviour:
- Reset (asynchronous, active-high), applies immediately and while held:
  - all DEPTH registers = 0; all busy bits = 0.
  - rd_data = 0 for all ports; rd_busy = 0; busy_any = 0.
  - Asserting reset mid-operation discards any in-flight write/claim of that cycle.
- Read path is purely combinational, zero latency, evaluated per port independently:
  - rd_addr == ZERO_REG → rd_data = 0, rd_busy = 0, regardless of any write/claim.
  - else if BYPASS=1 and wr_en and wr_addr == rd_addr → rd_data = wr_data and rd_busy = 0 (the write retires the claim this cycle).
  - else → rd_data = stored value, rd_busy = stored busy bit.
- Write, at posedge clock with wr_en=1 and wr_addr != ZERO_REG: register[wr_addr] <= wr_data; busy[wr_addr] <= 0, unless overridden by a same-cycle claim.
- Writes to ZERO_REG are discarded; its storage and busy bit remain 0 permanently.
- Claim, at posedge with claim_en=1, claim_addr != ZERO_REG and flush=0: busy[claim_addr] <= 1.
- Simultaneous events on the same register in one edge, priority high→low:
  - 1. reset.
  - 2. flush: all busy <= 0, and the same-cycle claim is dropped; the write still updates data.
  - 3. claim: busy <= 1, beating a same-cycle write release because the new producer is younger.
  - 4. write release.
- Claiming an already-busy register keeps busy=1; no counting, single outstanding producer assumed.
- Write to a non-busy register is legal (e.g. initial loads); data updates, busy stays 0.
- busy_any is registered-state derived: OR of stored busy bits after the edge, no bypass term.
- Address wrap: addresses are exactly ADDR_W wide; no out-of-range case exists.
- No reset value other than 0; no initial blocks required for synthesis.

Decomposition:
- Shared package regfile_pkg:
  - ZERO_REG_DEFAULT = 31.
  - ARM_DATA_W = 64.
  - ARM_ADDR_W = 5.
  - function rf_slice helper for flattened-bus indexing.
- One natural sub-module: regfile_read_port (one combinational read mux with zero/bypass/busy logic), instantiated NUM_RD times in a generate loop.
- Storage and scoreboard stay in the top.

Test Plan:
- Reset with all registers preloaded, then assert reset asynchronously mid-cycle → rd_data for X3/X7 = 0 immediately, busy_any = 0 before the next edge.
- Write X5 = 0xDEADBEEF_00000001 with rd_addr[0]=5 in the same cycle, BYPASS=1 → rd_data[0] = written value that cycle; with BYPASS=0, old value (0) that cycle and new value after the edge.
- Claim X9 at edge 1 → rd_busy=1 and busy_any=1 from edge 1; write X9 = 0x42 at edge 3 → rd_busy=0 from edge 3 (and combinationally during the write cycle when BYPASS=1), data = 0x42.
- Same edge: claim X4 and write X4 = 0x11 → data = 0x11, busy[4] = 1; then the same edge with flush=1 → busy[4] = 0 and data still updated.
- Write 0xFFFF to X31 and claim X31 → rd_data = 0 and rd_busy = 0 on all ports; busy_any unaffected.
- NUM_RD=3: three ports read X1, X1, X31 concurrently while X1 is written → ports 0/1 both bypass the new value, port 2 reads 0.
